// File: rtl/module_reset_sequencer_if.sv
// Reset-sequencer bus: lock flag in, staged resets / ready / loss count out.
// Optional: RST_SEQ_LOSS_CNT_EN adds the loss_cnt_o signal.
interface module_reset_sequencer_if #(
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 8
);
    logic                  locked_i;
    logic [NUM_STAGES-1:0] rst_n_o;
    logic                  ready_o;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0]      loss_cnt_o;
`endif

    // Elaboration-time guard on the width parameters.
    if (NUM_STAGES < 1 || NUM_STAGES > 8 || CNT_W < 1) begin : g_param_chk
        $error("module_reset_sequencer_if: parameter out of range");
    end

    // Sequencer side.
    modport master (
        input  locked_i,
        output rst_n_o,
        output ready_o
`ifdef RST_SEQ_LOSS_CNT_EN
        , output loss_cnt_o
`endif
    );

    // Consumer / clock-wizard side.
    modport slave (
        output locked_i,
        input  rst_n_o,
        input  ready_o
`ifdef RST_SEQ_LOSS_CNT_EN
        , input loss_cnt_o
`endif
    );
endinterface

// File: rtl/module_reset_sequencer.sv
// Staged active-low reset sequencer driven by a clock-wizard lock flag.
// Lock is synchronized, qualified for HOLD_CYCLES, then stages release in
// ascending order every STAGE_GAP cycles. Lock loss drops every stage at once.
// Optional: RST_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter.
module module_reset_sequencer #(
    parameter int HOLD_CYCLES = 1000,
    parameter int NUM_STAGES  = 2,
    parameter int STAGE_GAP   = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    module_reset_sequencer_if.master bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);

    typedef enum logic [1:0] {S_WAIT, S_STABLE, S_RELEASE, S_RUN} state_t;

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || HOLD_CYCLES < 1 ||
        STAGE_GAP < 1 || CNT_W < 1) begin : g_param_chk
        $error("module_reset_sequencer: parameter out of range");
    end

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d, hold_inc;
    logic [GW-1:0]         gap_q, gap_d, gap_inc;
    logic [NUM_STAGES-1:0] rel_q, rel_d, rel_next;
    logic                  sync1, lock_s;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= bus.locked_i;
            lock_s <= sync1;
        end
    end

    // State, counters and the thermometer-coded release register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_WAIT;
            hold_q  <= '0;
            gap_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rel_q   <= rel_d;
        end
    end

    assign hold_inc = hold_q + HW'(1);
    assign gap_inc  = gap_q + GW'(1);
    // Shifting in a one keeps the output a thermometer code.
    assign rel_next = (rel_q << 1) | NUM_STAGES'(1);

    // Next-state logic; lock loss is checked before any release so it wins.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rel_d   = rel_q;
        case (state_q)
            S_WAIT: begin
                rel_d  = '0;
                hold_d = '0;
                gap_d  = '0;
                if (lock_s) begin
                    if (HOLD_CYCLES == 1) begin
                        rel_d   = NUM_STAGES'(1);
                        state_d = (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
                    end else begin
                        hold_d  = HW'(1);
                        state_d = S_STABLE;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    // Dropout before any release is a restart, not a loss.
                    hold_d  = '0;
                    state_d = S_WAIT;
                end else if (hold_inc == HW'(HOLD_CYCLES)) begin
                    hold_d  = '0;
                    gap_d   = '0;
                    rel_d   = NUM_STAGES'(1);
                    state_d = (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
                end else begin
                    hold_d  = hold_inc;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    rel_d   = '0;
                    gap_d   = '0;
                    state_d = S_WAIT;
                end else if (gap_inc == GW'(STAGE_GAP)) begin
                    rel_d   = rel_next;
                    gap_d   = '0;
                    if (&rel_next) state_d = S_RUN;
                end else begin
                    gap_d   = gap_inc;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    rel_d   = '0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                rel_d   = '0;
                state_d = S_WAIT;
            end
        endcase
    end

    assign bus.rst_n_o = rel_q;
    assign bus.ready_o = (state_q == S_RUN);

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q;
    logic             loss_evt;

    // Only a drop after at least one stage has released counts as a loss.
    assign loss_evt = !lock_s && (state_q == S_RELEASE || state_q == S_RUN);

    // Saturating lock-loss counter.
    always_ff @(posedge clk) begin
        if (!rst)                          loss_q <= '0;
        else if (loss_evt && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
    end

    assign bus.loss_cnt_o = loss_q;
`endif
endmodule

// File: tb/tb_module_reset_sequencer.sv
// Directed bench for module_reset_sequencer (HOLD=8, GAP=4, STAGES=3, CNT_W=2).
// Edge E0 is the first edge sampling locked_i=1; outputs are read 1 time unit
// after each rising edge. Loss-count checks apply when RST_SEQ_LOSS_CNT_EN is set.
module tb_module_reset_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   e;

    module_reset_sequencer_if #(.NUM_STAGES(3), .CNT_W(2)) bus ();

    module_reset_sequencer #(
        .HOLD_CYCLES(8),
        .NUM_STAGES (3),
        .STAGE_GAP  (4),
        .CNT_W      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] rn, input logic rdy);
        chk({tag, ".rst_n"}, 32'(bus.rst_n_o), 32'(rn));
        chk({tag, ".ready"}, 32'(bus.ready_o), 32'(rdy));
    endtask

    task automatic chk_loss(input string tag, input int exp);
`ifdef RST_SEQ_LOSS_CNT_EN
        chk({tag, ".loss"}, 32'(bus.loss_cnt_o), 32'(exp));
`else
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_to(input int n);
        while (e < n) tick();
    endtask

    // Lock drop seen by the FSM two edges later; outputs low after L+2.
    task automatic drop(input int exp_loss);
        bus.locked_i = 1'b0;
        repeat (3) tick();
        chk_out("drop", 3'b000, 1'b0);
        chk_loss("drop", exp_loss);
    endtask

    // Re-acquire lock and wait (bounded) for the first stage release.
    task automatic acquire();
        bus.locked_i = 1'b1;
        for (int i = 0; i < 40 && !bus.rst_n_o[0]; i++) tick();
        chk("acquire.rst_n0", 32'(bus.rst_n_o[0]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        bus.locked_i = 1'b1;
        n_chk = 0;
        n_fail = 0;
        e = 0;

        // Reset held with lock present: everything stays in reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("reset", 3'b000, 1'b0);
            chk_loss("reset", 0);
        end

        // Nominal release: 001 @E9, 011 @E13, 111 + ready @E17.
        rst = 1'b1;
        e = -1;
        tick_to(8);  chk_out("nom.E8",  3'b000, 1'b0);
        tick_to(9);  chk_out("nom.E9",  3'b001, 1'b0);
        tick_to(12); chk_out("nom.E12", 3'b001, 1'b0);
        tick_to(13); chk_out("nom.E13", 3'b011, 1'b0);
        tick_to(16); chk_out("nom.E16", 3'b011, 1'b0);
        tick_to(17); chk_out("nom.E17", 3'b111, 1'b1);

        // Loss in RUN: outputs hold through L+1, drop after L+2.
        bus.locked_i = 1'b0;
        e = -1;
        tick_to(0); chk_out("run_loss.L",   3'b111, 1'b1);
        tick_to(1); chk_out("run_loss.L+1", 3'b111, 1'b1);
        tick_to(2); chk_out("run_loss.L+2", 3'b000, 1'b0);
        chk_loss("run_loss", 1);

        // Glitch in STABLE: low sampled at E5, re-rise at E6 -> release @E15.
        bus.locked_i = 1'b1;
        e = -1;
        tick_to(4);
        bus.locked_i = 1'b0;
        tick_to(5);
        bus.locked_i = 1'b1;
        tick_to(14); chk_out("glitch.E14", 3'b000, 1'b0);
        tick_to(15); chk_out("glitch.E15", 3'b001, 1'b0);
        chk_loss("glitch", 1);
        tick_to(19); chk_out("glitch.E19", 3'b011, 1'b0);
        tick_to(23); chk_out("glitch.E23", 3'b111, 1'b1);

        // Saturation: losses 2, 3, then held at 3.
        drop(2);
        acquire();
        drop(3);
        acquire();
        drop(3);
        acquire();
        drop(3);

        // Mid-release reset at 011, then a full hold is required again.
        bus.locked_i = 1'b1;
        e = -1;
        tick_to(13); chk_out("mid.E13", 3'b011, 1'b0);
        rst = 1'b0;
        tick();      chk_out("mid.rst", 3'b000, 1'b0);
        chk_loss("mid.rst", 0);
        rst = 1'b1;
        e = -1;
        tick_to(8);  chk_out("mid.E8", 3'b000, 1'b0);
        tick_to(9);  chk_out("mid.E9", 3'b001, 1'b0);

        // Collision: loss reaches the FSM on the E13 release edge.
        tick_to(10);
        bus.locked_i = 1'b0;
        tick_to(12); chk_out("coll.E12", 3'b001, 1'b0);
        tick_to(13); chk_out("coll.E13", 3'b000, 1'b0);
        tick_to(16); chk_out("coll.E16", 3'b000, 1'b0);
        chk_loss("coll", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/module_reset_sequencer.md
# module_reset_sequencer

Generates staged, synchronous active-low reset releases from the clocking-wizard `locked` flag for the clock-test logic and future consumers in the same clock domain. Sits between the clock wizard and the downstream test blocks. Reset release is qualified by a minimum stable-lock interval, then spread across several stages so consumers leave reset in a fixed order. On lock loss, all stage resets re-assert immediately.

## Interface
- `HOLD_CYCLES`, 1000: consecutive synchronized-high `locked_i` samples required before the first release; ≥1.
- `NUM_STAGES`, 2: number of staged reset outputs; 1–8.
- `STAGE_GAP`, 16: cycles between consecutive stage releases; ≥1.
- `CNT_W`, 8: width of the lock-loss counter.

Ports:
- `clk` in 1: block clock. All logic is in this domain.
- `rst` in 1: synchronous, active-low reset.
- `locked_i` in 1: clock-wizard lock flag. Asynchronous to `clk`.
- `rst_n_o` out `NUM_STAGES`: staged active-low resets. Bit k is released after bit k-1.
- `ready_o` out 1: high when every stage has been released.
- `loss_cnt_o` out `CNT_W`: saturating lock-loss count. Present only with `RST_SEQ_LOSS_CNT_EN`.

## Operation
- **Synchronizer.** `locked_i` passes through a 2-FF synchronizer; the output is `lock_s`. The FSM and counters use only `lock_s`.
- **FSM states:** WAIT, STABLE, RELEASE, RUN.
- **WAIT.** All `rst_n_o` = 0 and `ready_o` = 0. When `lock_s` = 1, go to STABLE with hold count = 1.
- **STABLE.** Each cycle with `lock_s` = 1 increments the hold count. When the count reaches `HOLD_CYCLES`, set `rst_n_o[0]` = 1. Then:
  - if `NUM_STAGES` = 1, go to RUN;
  - otherwise go to RELEASE with the gap count cleared.
  - If `lock_s` = 0, return to WAIT. The count clears and no loss is recorded.
- **RELEASE.** The gap counter counts to `STAGE_GAP`. When it reaches `STAGE_GAP`, release the next stage bit and clear the counter. Releasing the last bit moves the FSM to RUN.
- **RUN.** Steady state: all `rst_n_o` = 1 and `ready_o` = 1.
- **Lock loss.** `lock_s` = 0 while in RELEASE or RUN:
  - on the next edge, all `rst_n_o` = 0, `ready_o` = 0, and the FSM goes to WAIT;
  - the loss counter increments and saturates at all-ones.
- **Stage order.** Released bits never go low out of order: loss drops all bits together, and release is strictly by ascending index.
- **Output encoding.** `rst_n_o` is a thermometer code: bit k = 1 implies bits 0..k-1 = 1.
- **Counter widths.** Internal counters are sized with `$clog2`. Counters stop at their terminal value and never wrap.

## Timing
- **Reset values** (`rst` = 0 at an edge): `rst_n_o` = 0, `ready_o` = 0, `loss_cnt_o` = 0, FSM = WAIT, synchronizer flops = 0. `rst` has priority over all other inputs.
- **Release latency.** Let E0 be the first edge that samples `locked_i` = 1, with the input held high.
  - `lock_s` = 1 after E1.
  - `rst_n_o[0]` rises after edge E(`HOLD_CYCLES`+1).
  - `rst_n_o[k]` rises after edge E(`HOLD_CYCLES`+1+k·`STAGE_GAP`).
  - `ready_o` rises on the same edge as the last stage.
- **Loss latency.** `locked_i` sampled 0 at edge L drives `lock_s` = 0 after L+1; all outputs drop after L+2.
- **Glitch rejection.** A single-cycle low on `lock_s` during STABLE restarts the hold interval. It is not counted as a loss.
- **Simultaneous events.** If lock loss coincides with a stage-release edge, loss wins: no bit rises on that edge.
- **Mid-operation reset.** `rst` asserted in any state returns all outputs to their reset values on that edge.
- **Recovery.** After `rst` deasserts, the sequence restarts from WAIT regardless of `locked_i`. The full hold interval is required again.

## Configuration
- **Macro:** `RST_SEQ_LOSS_CNT_EN`.
- **Defined:** the `loss_cnt_o` port and the saturating `CNT_W`-bit counter exist.
- **Undefined:** both the port and the counter are removed. All other behaviour is identical.

## Test plan
Every scenario uses `HOLD_CYCLES`=8, `STAGE_GAP`=4, `NUM_STAGES`=3, `CNT_W`=2.
- **Reset values:** hold `rst` = 0 for 5 cycles with `locked_i` = 1 → `rst_n_o` = 3'b000, `ready_o` = 0, `loss_cnt_o` = 0 throughout.
- **Nominal release:** release `rst`, then `locked_i` rises at E0 → `rst_n_o` = 001 after E9, 011 after E13, 111 after E17; `ready_o` = 1 after E17.
- **Glitch in STABLE:** `locked_i` low for 1 cycle at E5, then high → no loss counted; release restarts, with `rst_n_o[0]` rising 9 edges after the re-rise is sampled.
- **Loss in RUN:** drop `locked_i` at edge L while in RUN → `rst_n_o` = 000 and `ready_o` = 0 after L+2; `loss_cnt_o` = 1.
- **Saturation:** force 4 losses → `loss_cnt_o` = 3 and stays 3. With the macro undefined, the build has no `loss_cnt_o` port.
- **Mid-release reset and collision:**
  - `rst` = 0 while `rst_n_o` = 011 → `rst_n_o` = 000 on that edge, and a full 9-edge hold is required after `rst` deasserts.
  - Loss landing on the E13 release edge → bit 1 never rises.
